// File: rtl/clk_meas_sched.sv
// clk_meas_sched: round-robin scheduler sharing one rate-measurement engine
// across NCLK monitored clocks. It drives the engine mux select, sequences
// settle/start/done, stores the latest rate per channel and keeps sticky
// out-of-range and timeout flags. Everything runs in the clk_ref domain.
module clk_meas_sched #(
  parameter int NCLK           = 4,
  parameter int CNT_W          = 32,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  localparam int CHW           = (NCLK > 1) ? $clog2(NCLK) : 1
) (
  input  logic                  clk_ref,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [NCLK-1:0]       chan_mask,
  input  logic                  clear,
  input  logic [NCLK*CNT_W-1:0] rate_min,
  input  logic [NCLK*CNT_W-1:0] rate_max,
  output logic [CHW-1:0]        sel,
  output logic                  meas_start,
  input  logic                  meas_done,
  input  logic [CNT_W-1:0]      meas_value,
  output logic [NCLK*CNT_W-1:0] rate_out,
  output logic [NCLK-1:0]       valid,
  output logic [NCLK-1:0]       out_of_range,
  output logic [NCLK-1:0]       timeout,
  output logic                  scan_done,
  output logic [15:0]           scan_count
);

  // One counter serves both the settle delay and the WAIT timeout, so it is
  // sized for the larger of the two.
  localparam int MAX_CYCLES = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, START, WAIT, STORE} state_t;

  state_t          state_reg, state_next;
  logic [CHW-1:0]  cur_reg;
  logic [CW-1:0]   cnt_reg;
  logic            first_reg;
  logic            scan_done_reg;
  logic [15:0]     scan_count_reg;

  logic            found_hi;
  logic [CHW-1:0]  idx_hi;
  logic [CHW-1:0]  idx_lo;
  logic [CHW-1:0]  next_ch;
  logic            run_ok;
  logic            wait_done;
  logic            wait_expire;
  logic            in_store;

  assign run_ok      = enable && (|chan_mask);
  assign wait_done   = (state_reg == WAIT) && meas_done;
  assign wait_expire = (state_reg == WAIT) && !meas_done && (cnt_reg == TIMEOUT_LAST);
  assign in_store    = (state_reg == STORE);

  // Find the lowest masked channel above cur and the lowest masked channel overall.
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NCLK - 1; i >= 0; i--) begin
      if (chan_mask[i]) begin
        idx_lo = CHW'(i);
        if (CHW'(i) > cur_reg) begin
          found_hi = 1'b1;
          idx_hi   = CHW'(i);
        end
      end
    end
    // The very first sweep after reset starts at index 0 inclusive.
    next_ch = (first_reg || !found_hi) ? idx_lo : idx_hi;
  end

  // Next-state logic. START always proceeds to WAIT: once the engine has
  // been pulsed its answer (or timeout) must be consumed before idling.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (run_ok) state_next = SELECT;
      SELECT:  state_next = run_ok ? SETTLE : IDLE;
      SETTLE: begin
        if (!enable)                     state_next = IDLE;
        else if (cnt_reg == SETTLE_LAST) state_next = START;
      end
      START:   state_next = WAIT;
      WAIT:    if (wait_done || wait_expire) state_next = STORE;
      STORE:   state_next = run_ok ? SELECT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, channel pointer, shared cycle counter and sweep bookkeeping.
  always_ff @(posedge clk_ref or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      cur_reg        <= '0;
      cnt_reg        <= '0;
      first_reg      <= 1'b1;
      scan_done_reg  <= 1'b0;
      scan_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      scan_done_reg <= 1'b0;
      case (state_reg)
        SELECT: begin
          cnt_reg <= '0;
          if (state_next == SETTLE) begin
            cur_reg   <= next_ch;
            first_reg <= 1'b0;
          end
        end
        SETTLE:  cnt_reg <= cnt_reg + 1'b1;
        START:   cnt_reg <= '0;
        WAIT:    cnt_reg <= cnt_reg + 1'b1;
        STORE: begin
          // Sweep ends when nothing masked remains above the current channel.
          if (!found_hi) begin
            scan_done_reg  <= 1'b1;
            scan_count_reg <= scan_count_reg + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sel        = cur_reg;
  assign meas_start = (state_reg == START);
  assign scan_done  = scan_done_reg;
  assign scan_count = scan_count_reg;

  // Per-channel result storage and sticky flags.
  genvar gi;
  generate
    for (gi = 0; gi < NCLK; gi++) begin : g_chan
      logic [CNT_W-1:0] rate_reg;
      logic             valid_reg;
      logic             oor_reg;
      logic             tmo_reg;
      logic             hit;
      logic             out_lim;
      logic [CNT_W-1:0] lim_min;
      logic [CNT_W-1:0] lim_max;

      assign hit     = (cur_reg == CHW'(gi));
      assign lim_min = rate_min[gi*CNT_W +: CNT_W];
      assign lim_max = rate_max[gi*CNT_W +: CNT_W];
      assign out_lim = (rate_reg < lim_min) || (rate_reg > lim_max);

      // Capture result or timeout; a new set beats a simultaneous clear.
      always_ff @(posedge clk_ref or negedge aresetn) begin
        if (!aresetn) begin
          rate_reg  <= '0;
          valid_reg <= 1'b0;
          oor_reg   <= 1'b0;
          tmo_reg   <= 1'b0;
        end else begin
          if (wait_done && hit) begin
            rate_reg  <= meas_value;
            valid_reg <= 1'b1;
          end else if (wait_expire && hit) begin
            rate_reg  <= '0;
            valid_reg <= 1'b0;
          end
          oor_reg <= (oor_reg && !clear) || (in_store && hit && valid_reg && out_lim);
          tmo_reg <= (tmo_reg && !clear) || (wait_expire && hit);
        end
      end

      assign rate_out[gi*CNT_W +: CNT_W] = rate_reg;
      assign valid[gi]        = valid_reg;
      assign out_of_range[gi] = oor_reg;
      assign timeout[gi]      = tmo_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clk_meas_sched.sv
// Directed testbench for clk_meas_sched with NCLK=4, SETTLE=4, TIMEOUT=64.
// The engine is modelled inline: it answers a chosen number of cycles after
// meas_start, or stays silent to provoke a timeout.
module tb_clk_meas_sched;

  logic         clk_ref    = 1'b0;
  logic         aresetn    = 1'b0;
  logic         enable     = 1'b0;
  logic [3:0]   chan_mask  = 4'b1011;
  logic         clear      = 1'b0;
  logic [127:0] rate_min;
  logic [127:0] rate_max;
  logic [1:0]   sel;
  logic         meas_start;
  logic         meas_done  = 1'b0;
  logic [31:0]  meas_value = 32'd0;
  logic [127:0] rate_out;
  logic [3:0]   valid;
  logic [3:0]   out_of_range;
  logic [3:0]   timeout;
  logic         scan_done;
  logic [15:0]  scan_count;

  int checks = 0;
  int errors = 0;

  clk_meas_sched #(
    .NCLK(4),
    .CNT_W(32),
    .SETTLE_CYCLES(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_ref(clk_ref),
    .aresetn(aresetn),
    .enable(enable),
    .chan_mask(chan_mask),
    .clear(clear),
    .rate_min(rate_min),
    .rate_max(rate_max),
    .sel(sel),
    .meas_start(meas_start),
    .meas_done(meas_done),
    .meas_value(meas_value),
    .rate_out(rate_out),
    .valid(valid),
    .out_of_range(out_of_range),
    .timeout(timeout),
    .scan_done(scan_done),
    .scan_count(scan_count)
  );

  always #5 clk_ref = ~clk_ref;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag, input logic [1:0] exp_sel);
    int n = 0;
    while (n < 200 && !meas_start) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, 128'(meas_start), 128'd1);
    chk({tag, "_sel"}, 128'(sel), 128'(exp_sel));
  endtask

  task automatic start_latency(input string tag, input int exp);
    int n = 0;
    while (n < 40 && !meas_start) begin
      tick();
      n++;
    end
    chk(tag, 128'(n), 128'(exp));
  endtask

  // Engine answers dly cycles after the START cycle; returns in the STORE cycle.
  task automatic respond(input logic [31:0] val, input int dly);
    repeat (dly) tick();
    meas_done  = 1'b1;
    meas_value = val;
    tick();
    meas_done  = 1'b0;
    meas_value = 32'd0;
  endtask

  task automatic no_start(input string tag, input int n);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (meas_start) cnt++;
    end
    chk(tag, 128'(cnt), 128'd0);
  endtask

  initial begin
    rate_min = '0;
    rate_max = '1;
    rate_min[32 +: 32] = 32'd900;
    rate_max[32 +: 32] = 32'd950;

    // Reset values
    repeat (2) tick();
    chk("rst_sel", 128'(sel), 128'd0);
    chk("rst_start", 128'(meas_start), 128'd0);
    chk("rst_rate", rate_out, 128'd0);
    chk("rst_valid", 128'(valid), 128'd0);
    chk("rst_oor", 128'(out_of_range), 128'd0);
    chk("rst_tmo", 128'(timeout), 128'd0);
    chk("rst_sdone", 128'(scan_done), 128'd0);
    chk("rst_scount", 128'(scan_count), 128'd0);
    aresetn = 1'b1;
    tick();

    // Sweep 1, mask 1011: start 6 cycles after enable edge (SELECT + 4 SETTLE)
    enable = 1'b1;
    start_latency("s1_latency", 6);
    wait_start("s1c0", 2'd0);
    respond(32'd1000, 10);
    chk("s1c0_rate", 128'(rate_out[0 +: 32]), 128'd1000);
    chk("s1c0_valid", 128'(valid), 128'b0001);
    tick();
    chk("s1c0_sdone", 128'(scan_done), 128'd0);
    wait_start("s1c1", 2'd1);
    respond(32'd1001, 10);
    chk("s1c1_rate", 128'(rate_out[32 +: 32]), 128'd1001);
    chk("s1c1_oor_early", 128'(out_of_range), 128'b0000);
    tick();
    chk("s1c1_oor", 128'(out_of_range), 128'b0010);
    wait_start("s1c3", 2'd3);
    respond(32'd1003, 10);
    chk("s1c3_valid", 128'(valid), 128'b1011);
    chk("s1c3_sdone_early", 128'(scan_done), 128'd0);
    tick();
    chk("s1_sdone", 128'(scan_done), 128'd1);
    chk("s1_scount", 128'(scan_count), 128'd1);
    chk("s1_rates", rate_out, {32'd1003, 32'd0, 32'd1001, 32'd1000});

    // Clear pulse drops the sticky range flag
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_oor", 128'(out_of_range), 128'b0000);

    // Sweep 2: wrap to ch0; clear coincident with re-set keeps the bit
    wait_start("s2c0", 2'd0);
    respond(32'd1000, 10);
    tick();
    chk("s2c0_sdone", 128'(scan_done), 128'd0);
    wait_start("s2c1", 2'd1);
    respond(32'd1001, 10);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_vs_set", 128'(out_of_range), 128'b0010);
    wait_start("s2c3", 2'd3);
    respond(32'd1003, 10);
    tick();
    chk("s2_sdone", 128'(scan_done), 128'd1);
    chk("s2_scount", 128'(scan_count), 128'd2);
    chan_mask = 4'b1111;

    // Sweep 3, all channels answer
    wait_start("s3c0", 2'd0);
    respond(32'd1000, 10);
    wait_start("s3c1", 2'd1);
    respond(32'd1001, 10);
    wait_start("s3c2", 2'd2);
    respond(32'd1002, 10);
    chk("s3c2_rate", 128'(rate_out[64 +: 32]), 128'd1002);
    wait_start("s3c3", 2'd3);
    respond(32'd1003, 10);
    tick();
    chk("s3_scount", 128'(scan_count), 128'd3);

    // Sweep 4: ch2 silent -> timeout after 64 WAIT cycles
    wait_start("s4c0", 2'd0);
    respond(32'd1000, 10);
    wait_start("s4c1", 2'd1);
    respond(32'd1001, 10);
    wait_start("s4c2", 2'd2);
    repeat (64) tick();
    chk("tmo_not_yet", 128'(timeout), 128'b0000);
    chk("tmo_valid_pre", 128'(valid), 128'b1111);
    tick();
    chk("tmo_flag", 128'(timeout), 128'b0100);
    chk("tmo_valid", 128'(valid), 128'b1011);
    chk("tmo_rate", 128'(rate_out[64 +: 32]), 128'd0);
    // ch3: done arrives in the very cycle the timeout would expire
    wait_start("s4c3", 2'd3);
    respond(32'd4003, 64);
    chk("race_rate", 128'(rate_out[96 +: 32]), 128'd4003);
    chk("race_tmo", 128'(timeout), 128'b0100);
    chk("race_valid", 128'(valid), 128'b1011);
    tick();
    chk("s4_scount", 128'(scan_count), 128'd4);

    // Enable dropped during SETTLE of ch0
    tick();
    enable = 1'b0;
    tick();
    chk("settle_drop_sel", 128'(sel), 128'd0);
    no_start("settle_drop_nostart", 20);

    // Re-enable from IDLE, then drop enable during WAIT on ch1
    enable = 1'b1;
    start_latency("reen_latency", 6);
    wait_start("reen", 2'd1);
    repeat (3) tick();
    enable = 1'b0;
    respond(32'd2001, 7);
    chk("wait_drop_rate", 128'(rate_out[32 +: 32]), 128'd2001);
    no_start("wait_drop_nostart", 30);

    // Empty mask never leaves IDLE
    chan_mask = 4'b0000;
    enable    = 1'b1;
    no_start("mask0_nostart", 30);
    chk("mask0_scount", 128'(scan_count), 128'd4);

    // Mask changed mid-WAIT on ch0: ch0 still stored, next channel is 2
    chan_mask = 4'b0001;
    wait_start("mchg_c0", 2'd0);
    repeat (2) tick();
    chan_mask = 4'b0100;
    respond(32'd3000, 8);
    chk("mchg_rate", 128'(rate_out[0 +: 32]), 128'd3000);
    tick();
    chk("mchg_sdone", 128'(scan_done), 128'd0);
    wait_start("mchg_c2", 2'd2);

    // Asynchronous reset in WAIT
    repeat (3) tick();
    #2;
    aresetn = 1'b0;
    #1;
    chk("areset_sel", 128'(sel), 128'd0);
    chk("areset_start", 128'(meas_start), 128'd0);
    chk("areset_rate", rate_out, 128'd0);
    chk("areset_valid", 128'(valid), 128'd0);
    chk("areset_oor", 128'(out_of_range), 128'd0);
    chk("areset_tmo", 128'(timeout), 128'd0);
    chk("areset_scount", 128'(scan_count), 128'd0);
    enable = 1'b0;
    tick();
    aresetn = 1'b1;
    repeat (2) tick();
    meas_done  = 1'b1;
    meas_value = 32'd5555;
    tick();
    meas_done  = 1'b0;
    meas_value = 32'd0;
    tick();
    chk("late_done_rate", rate_out, 128'd0);
    chk("late_done_valid", 128'(valid), 128'd0);
    chk("late_done_start", 128'(meas_start), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
